dac_spi_tx: RTL
===============

Name: dac_spi_tx

Overview:
- Responder end of the toggle request/acknowledge handshake driven by the waveform generator.
- On each data_req transition, captures the 12-bit DAC code and serializes it as a 16-bit SPI mode-0 frame to an MCP4921-class DAC.
- Returns a one-cycle data_ack pulse when the frame is complete.
- Sits between the waveform generator and the DAC pins, in the same clock domain as the generator.

Parameters:
- CLK_DIV, 2, clk cycles per sclk half-period (≥1); sclk = clk/(2*CLK_DIV).
- CONFIG, 4'b0011, frame bits [15:12]: A/B=0, BUF=0, GA=1 (1x), SHDN=1 (active).

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- data_req  input  1  request toggle; every transition (0→1 or 1→0) is one request.
- data  input  12  DAC code; sampled on the cycle a transfer starts.
- data_ack  output  1  one-cycle pulse at frame completion.
- busy  output  1  high while cs_n is low or during the inter-frame gap.
- cs_n  output  1  DAC chip select, active low.
- sclk  output  1  SPI clock, idles low.
- mosi  output  1  SPI data, MSB first.

Behaviour:
- One clock, one reset. Reset is asynchronous and active-high, named reset. The clock is clk.
- Reset values:
  - cs_n=1, sclk=0, mosi=0, data_ack=0, busy=0.
  - req_q=0 (matches the generator's data_req reset value), pending=0, state=IDLE, counters=0.
- Request detection:
  - req_q registers data_req every cycle; edge = data_req ^ req_q.
  - No synchronizer; data_req is same-domain.
- pending flag:
  - Set by any edge seen while state≠IDLE.
  - Cleared when a transfer starts.
  - Multiple edges during a transfer collapse to one pending request.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - If edge or pending at rising edge t: frame ← {CONFIG, data}, cs_n←0, mosi←frame[15], bit counter←15, div counter←0, busy←1, go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - The div counter counts 0..CLK_DIV-1; at its terminal count sclk toggles.
  - Rising sclk occurs at t+(2k+1)*CLK_DIV for bit k=0..15; mosi is stable across each rising edge.
  - On each falling sclk (t+(2k+2)*CLK_DIV, k<15), mosi ← next lower bit.
  - On the 16th falling sclk (t+32*CLK_DIV), in the same cycle:
    - cs_n←1, mosi←0
    - data_ack←1 for exactly one cycle
    - go to GAP.
- GAP:
  - cs_n held high for CLK_DIV cycles (DAC latch / min CS-high time).
  - At t+33*CLK_DIV, if pending (or edge that cycle): start a new frame exactly as from IDLE. Otherwise go to IDLE with busy←0.
- Latency: request edge at t → cs_n low at t, data_ack at t+32*CLK_DIV.
  - Minimum frame period 33*CLK_DIV cycles.
- Generator interaction: the generator toggles data_req in response to data_ack, so back-to-back streaming is the normal case. The latest data value at restart time is used; intermediate values are dropped by design.
- Edge in the same cycle as data_ack: recorded as pending; no request is lost.
- data changing while SHIFT is active has no effect on the frame in flight.
- Reset mid-frame: immediate abort, all outputs to reset values, no data_ack, pending discarded.
- Counter widths: div counter $clog2(CLK_DIV)+1 bits; bit counter 4 bits. No wrap-around beyond the defined ranges.

Test Plan:
- Reset then idle: hold reset high, then release with data_req static → cs_n=1, sclk=0, busy=0, data_ack never asserts over 200 cycles.
- Single request: CLK_DIV=2, data=12'd819, toggle data_req 0→1 → cs_n low at t, mosi captured on 16 sclk rising edges = 16'h3333, data_ack single pulse at t+64, cs_n high at t+64, busy low at t+66.
- Falling-edge request: after the previous frame, data=12'd4095, toggle data_req 1→0 → frame 16'h3FFF, one data_ack.
- Coalesced requests: during SHIFT toggle data_req three times, final data=12'd2458 → exactly one further frame 16'h399A starting at t+66, no third frame.
- Streaming loop: connect data_ack back through a model that toggles data_req one cycle after each ack → continuous frames with period 66 cycles, each frame carrying the current data.
- Reset mid-frame: assert reset during bit 7 → cs_n=1, sclk=0, mosi=0 asynchronously, no data_ack; after release, a new data_req toggle produces a complete correct frame.

Source files
------------

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - toggle-handshake responder serializing 12-bit codes as 16-bit SPI mode-0 DAC frames
`timescale 1ns/1ps

module dac_spi_tx #(
    parameter int         CLK_DIV = 2,
    parameter logic [3:0] CONFIG  = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic [11:0] data,
    output logic        data_ack,
    output logic        busy,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi
);

    localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           r_state;
    logic             r_req_q;
    logic             r_pending;
    logic [15:0]      r_frame;
    logic [3:0]       r_bit;
    logic [DIV_W-1:0] r_div;
    logic             r_cs_n;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_ack;
    logic             r_busy;

    state_t           w_state_nxt;
    logic             w_pending_nxt;
    logic [15:0]      w_frame_nxt;
    logic [3:0]       w_bit_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_cs_n_nxt;
    logic             w_sclk_nxt;
    logic             w_mosi_nxt;
    logic             w_ack_nxt;
    logic             w_busy_nxt;
    logic             w_edge;
    logic             w_div_tc;
    logic             w_start;

    assign w_edge   = data_req ^ r_req_q;
    assign w_div_tc = (r_div == DIV_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_nxt   = r_frame;
        w_bit_nxt     = r_bit;
        w_div_nxt     = r_div;
        w_cs_n_nxt    = r_cs_n;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_ack_nxt     = 1'b0;
        w_busy_nxt    = r_busy;
        w_start       = 1'b0;
        w_pending_nxt = r_pending;

        case (r_state)
            S_IDLE: begin
                if (w_edge || r_pending) begin
                    w_start = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_div_tc) begin
                    w_div_nxt  = '0;
                    w_sclk_nxt = ~r_sclk;
                    // Falling sclk: advance to the next bit or close the frame.
                    if (r_sclk) begin
                        if (r_bit == 4'd0) begin
                            w_cs_n_nxt  = 1'b1;
                            w_mosi_nxt  = 1'b0;
                            w_ack_nxt   = 1'b1;
                            w_state_nxt = S_GAP;
                        end else begin
                            w_bit_nxt  = r_bit - 4'd1;
                            w_mosi_nxt = r_frame[r_bit - 4'd1];
                        end
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (w_div_tc) begin
                    w_div_nxt = '0;
                    if (w_edge || r_pending) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A start consumes the current edge and any collapsed pending request.
        if (w_start) begin
            w_frame_nxt   = {CONFIG, data};
            w_cs_n_nxt    = 1'b0;
            w_sclk_nxt    = 1'b0;
            w_mosi_nxt    = CONFIG[3];
            w_bit_nxt     = 4'd15;
            w_div_nxt     = '0;
            w_busy_nxt    = 1'b1;
            w_state_nxt   = S_SHIFT;
            w_pending_nxt = 1'b0;
        end else if (w_edge && (r_state != S_IDLE)) begin
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_req_q   <= 1'b0;
            r_pending <= 1'b0;
            r_frame   <= '0;
            r_bit     <= '0;
            r_div     <= '0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_q   <= data_req;
            r_pending <= w_pending_nxt;
            r_frame   <= w_frame_nxt;
            r_bit     <= w_bit_nxt;
            r_div     <= w_div_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign data_ack = r_ack;
    assign busy     = r_busy;
    assign cs_n     = r_cs_n;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;

endmodule
